muldiv_sequencer: RTL and testbench

- Multi-cycle iterative multiply/divide unit with its own sequencing FSM.
- Takes the single-cycle `a * b` / `a / b` paths out of the ALU's critical path.
- The core issues a request on a start/done handshake and freezes its PC register while `stall` is high.
- On completion the core consumes `result` and the register file writes it back.

---
 rtl/muldiv_sequencer.sv | 132 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative unsigned multiply / divide unit with its own sequencing FSM.
//   It keeps the wide a*b and a/b paths out of the ALU's single-cycle
//   critical path. One iteration is done per clock, so an operation takes
//   WIDTH cycles after acceptance. A divide by zero skips the iterations.
//
// Ports
//   clock       in   system clock, rising-edge
//   reset_      in   asynchronous active-low reset
//   start       in   request strobe, sampled only in IDLE
//   op          in   0 = MUL (low WIDTH bits of a*b), 1 = DIV (unsigned a/b)
//   a, b        in   operands (multiplicand/dividend, multiplier/divisor)
//   busy        out  high while iterating (MUL or DIV state)
//   stall       out  combinational PC freeze: (IDLE & start) | busy
//   done        out  one-cycle completion pulse (DONE state)
//   result      out  product or quotient, held until the next completion
//   remainder   out  DIV remainder (0 after MUL)
//   div_by_zero out  set with done for DIV with b == 0
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  // acc is the product accumulator for MUL and the partial remainder for DIV.
  // After each restoring step the remainder is below the divisor, so only the
  // shifted value needs the extra bit; it lives in r_sh, not in the register.
  logic [WIDTH-1:0] acc;
  // opa: multiplicand (shifts left) or dividend/quotient (shifts left).
  // opb: multiplier (shifts right) or divisor (constant).
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic [WIDTH-1:0] mul_acc_n;
  logic [WIDTH:0]   r_sh;
  logic             r_ge;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] q_n;

  always_comb begin
    mul_acc_n = acc + (opb[0] ? opa : '0);
    r_sh      = {acc, opa[WIDTH-1]};
    r_ge      = (r_sh >= {1'b0, opb});
    q_n       = {opa[WIDTH-2:0], r_ge};
    r_n       = r_ge ? WIDTH'(r_sh - {1'b0, opb}) : r_sh[WIDTH-1:0];
  end

  assign busy  = (state == MUL) || (state == DIV);
  assign done  = (state == DONE);
  assign stall = ((state == IDLE) && start) || busy;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      counter     <= '0;
      acc         <= '0;
      opa         <= '0;
      opb         <= '0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            counter     <= '0;
            acc         <= '0;
            opa         <= a;
            opb         <= b;
            div_by_zero <= 1'b0;
            if (!op) begin
              state <= MUL;
            end else if (b != '0) begin
              state <= DIV;
            end else begin
              // Divide by zero completes immediately with RISC-V style values.
              result      <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end
        end
        MUL: begin
          acc     <= mul_acc_n;
          opa     <= opa << 1;
          opb     <= opb >> 1;
          counter <= counter + CNT_W'(1);
          if (counter == LAST) begin
            result    <= mul_acc_n;
            remainder <= '0;
            state     <= DONE;
          end
        end
        DIV: begin
          acc     <= r_n;
          opa     <= q_n;
          counter <= counter + CNT_W'(1);
          if (counter == LAST) begin
            result    <= q_n;
            remainder <= r_n;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed bench for muldiv_sequencer (WIDTH=32): reset/idle, MUL and DIV
//   vectors, divide by zero, back-to-back requests, operand changes and an
//   ignored start while busy, and an asynchronous reset mid-operation.
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset_;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock       (clock),
    .reset_      (reset_),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to completion. elat is the number of
  // rising edges after the accepting edge until done is observed.
  task automatic run_op(input string nm, input logic o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] er,
                        input logic [31:0] erem, input logic edbz, input int elat);
    int   n;
    logic seen_busy;
    @(negedge clock);
    op = o; a = av; b = bv; start = 1'b1;
    #1 check({nm, "_stall_req"}, 32'(stall), 32'd1);
    @(posedge clock);
    #1 start = 1'b0;
    n = 0;
    seen_busy = busy;
    while (!done && n < 40) begin
      @(posedge clock);
      #1;
      n++;
      seen_busy = seen_busy | busy;
    end
    check({nm, "_latency"}, 32'(n), 32'(elat));
    check({nm, "_result"}, result, er);
    check({nm, "_remainder"}, remainder, erem);
    check({nm, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    check({nm, "_busy_seen"}, 32'(seen_busy), 32'(elat != 0));
    check({nm, "_stall_done"}, 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    check({nm, "_done_once"}, 32'(done), 32'd0);
    check({nm, "_idle_busy"}, 32'(busy), 32'd0);
    check({nm, "_result_held"}, result, er);
  endtask

  initial begin
    int pulses;
    logic [31:0] first_res;

    reset_ = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_result", result, 32'd0);
    check("idle_rem", remainder, 32'd0);
    check("idle_dbz", 32'(div_by_zero), 32'd0);

    run_op("mul7x6",   1'b0, 32'd7,          32'd6, 32'd42,         32'd0,   1'b0, 32);
    run_op("div100_7", 1'b1, 32'd100,        32'd7, 32'd14,         32'd2,   1'b0, 32);
    run_op("mulwrap",  1'b0, 32'hFFFF_FFFF,  32'd2, 32'hFFFF_FFFE,  32'd0,   1'b0, 32);
    run_op("div5_9",   1'b1, 32'd5,          32'd9, 32'd0,          32'd5,   1'b0, 32);
    run_op("dbz",      1'b1, 32'd123,        32'd0, 32'hFFFF_FFFF,  32'd123, 1'b1, 0);
    // Issued in the IDLE cycle right after the previous DONE.
    run_op("b2b_div",  1'b1, 32'd1000,       32'd10, 32'd100,       32'd0,   1'b0, 32);

    // Operands change and a DIV start is pulsed while the MUL is running.
    @(negedge clock);
    op = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    pulses = 0;
    first_res = '0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (i == 9) begin
        a = 32'd50; b = 32'd4; op = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done) begin
        pulses++;
        if (pulses == 1) first_res = result;
      end
    end
    check("busy_chg_pulses", 32'(pulses), 32'd1);
    check("busy_chg_result", first_res, 32'd15);
    check("busy_chg_idle", 32'(busy), 32'd0);

    // Asynchronous reset between edges aborts an in-flight DIV.
    @(negedge clock);
    op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (16) @(posedge clock);
    #3 reset_ = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    check("arst_no_done", 32'(pulses), 32'd0);
    run_op("mul9x9", 1'b0, 32'd9, 32'd9, 32'd81, 32'd0, 1'b0, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
